// File: rtl/fetch_pkg.sv
// Shared types and constants for the stage-1 instruction fetch slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] op;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Fetch addresses are word aligned; low address bits are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between fetch_unit (master) and its environment: imem, execute redirect, decode.
interface fetch_if;
  import fetch_pkg::*;

  // valid/ready: a transfer happens on a rising clk edge where valid && ready are both high.
  // Once the producer raises valid it holds valid and payload stable until that edge (a redirect
  // may withdraw a fetch request). imem responses and redirects are valid-only, one cycle each.
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [ILEN-1:0] dec_op;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_op, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_op, dec_pc,
    output dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush beats push/pop, head is the oldest slot.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Stage-1 fetch: PC, credit-limited imem requests, in-order response buffering, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            req_fire;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic            dec_valid_int;

  // In-flight requests plus buffered entries never exceed DEPTH, so a push always has room.
  assign credit_used        = {1'b0, inflight} + {1'b0, fifo_count};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credit_used < DEPTH_C);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign resp_drop = (drop_cnt != '0);
  assign push      = bus.imem_resp_valid && !resp_drop && !bus.redirect_valid;
  assign push_data = '{op: bus.imem_resp_data, pc: resp_pc_q};

  assign dec_valid_int = (fifo_count != '0) && !bus.redirect_valid;
  assign pop           = dec_valid_int && bus.dec_ready;
  assign bus.dec_valid = dec_valid_int;
  assign bus.dec_op    = head.op;
  assign bus.dec_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      inflight  <= '0;
      drop_cnt  <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      pc_q      <= align_pc(bus.redirect_pc);
      resp_pc_q <= align_pc(bus.redirect_pc);
      inflight  <= inflight - CW'(bus.imem_resp_valid);
      drop_cnt  <= inflight - CW'(bus.imem_resp_valid);
    end else begin
      if (req_fire) pc_q <= pc_q + PC_STEP;
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);
      if (bus.imem_resp_valid) begin
        if (resp_drop) drop_cnt  <= drop_cnt - 1'b1;
        else           resp_pc_q <= resp_pc_q + PC_STEP;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (fifo_count),
    .head      (head)
  );

  resp_needs_request: assert property (@(posedge clk) disable iff (rst)
    bus.imem_resp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem latency model, decode scoreboard, hand-computed checks.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int lat;
  int found;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [63:0] exp_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait to mid-cycle where combinational outputs have settled.
  task automatic settle();
    @(negedge clk);
  endtask

  // Record this cycle's handshakes, then advance one clock and drive due memory responses.
  task automatic step();
    logic [63:0] e;
    if (bus_if.redirect_valid) begin
      exp_q.delete();
    end else if (bus_if.dec_valid && bus_if.dec_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check("sb_decode", {bus_if.dec_op, bus_if.dec_pc}, e);
    end
    if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
      mem_addr_q.push_back(bus_if.imem_req_addr);
      mem_due_q.push_back(cyc + lat);
      exp_q.push_back({word_at(bus_if.imem_req_addr), bus_if.imem_req_addr});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
      bus_if.imem_resp_valid = 1'b1;
      bus_if.imem_resp_data  = word_at(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      bus_if.imem_resp_valid = 1'b0;
      bus_if.imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset(input int new_lat);
    rst                    = 1'b1;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_pc     = '0;
    mem_addr_q.delete();
    mem_due_q.delete();
    exp_q.delete();
    lat = new_lat;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst                    = 1'b1;
    bus_if.imem_req_ready  = 1'b1;
    bus_if.dec_ready       = 1'b1;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_pc     = '0;
    lat = 1;
    cyc = 0;

    @(posedge clk);
    #1;
    check("rst_req_valid", bus_if.imem_req_valid, 0);
    check("rst_dec_valid", bus_if.dec_valid, 0);
    check("rst_dec_op", bus_if.dec_op, 0);
    check("rst_dec_pc", bus_if.dec_pc, 0);
    check("rst_req_addr", bus_if.imem_req_addr, 32'h0);

    // 1: streaming with 1-cycle memory
    do_reset(1);
    settle(); check("t1_c1_req_valid", bus_if.imem_req_valid, 1);
    check("t1_c1_addr", bus_if.imem_req_addr, 32'h0); step();
    settle(); check("t1_c2_dec_valid", bus_if.dec_valid, 0);
    check("t1_c2_addr", bus_if.imem_req_addr, 32'h4); step();
    settle(); check("t1_c3_dec_valid", bus_if.dec_valid, 1);
    check("t1_c3_dec_pc", bus_if.dec_pc, 32'h0);
    check("t1_c3_dec_op", bus_if.dec_op, 32'hC0DE_0000);
    check("t1_c3_addr", bus_if.imem_req_addr, 32'h8); step();
    for (int i = 3; i < 10; i++) begin
      settle();
      check("t1_stream_addr", bus_if.imem_req_addr, 64'(4 * i));
      check("t1_stream_dec_pc", bus_if.dec_pc, 64'(4 * (i - 2)));
      step();
    end

    // 2: decode stalled, credit limit, single pop frees exactly one request
    do_reset(1);
    bus_if.dec_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("t2_req_valid", bus_if.imem_req_valid, 1);
      check("t2_req_addr", bus_if.imem_req_addr, 64'(4 * (i - 1)));
      step();
    end
    settle(); check("t2_c5_req_valid", bus_if.imem_req_valid, 0); step();
    for (int i = 6; i <= 7; i++) begin
      settle();
      check("t2_full_req_valid", bus_if.imem_req_valid, 0);
      check("t2_full_dec_valid", bus_if.dec_valid, 1);
      step();
    end
    bus_if.dec_ready = 1'b1;
    settle(); check("t2_c8_dec_pc", bus_if.dec_pc, 32'h0);
    check("t2_c8_req_valid", bus_if.imem_req_valid, 0); step();
    bus_if.dec_ready = 1'b0;
    settle(); check("t2_c9_req_valid", bus_if.imem_req_valid, 1);
    check("t2_c9_addr", bus_if.imem_req_addr, 32'h10); step();
    settle(); check("t2_c10_req_valid", bus_if.imem_req_valid, 0); step();
    settle(); check("t2_c11_req_valid", bus_if.imem_req_valid, 0);
    check("t2_c11_dec_valid", bus_if.dec_valid, 1);
    check("t2_c11_dec_pc", bus_if.dec_pc, 32'h4); step();

    // 3: 3-cycle memory, redirect with two requests in flight
    do_reset(3);
    bus_if.dec_ready = 1'b1;
    settle(); step();
    settle(); step();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h100;
    settle(); check("t3_redir_req_valid", bus_if.imem_req_valid, 0);
    check("t3_redir_dec_valid", bus_if.dec_valid, 0); step();
    bus_if.redirect_valid = 1'b0;
    settle(); check("t3_c4_req_valid", bus_if.imem_req_valid, 1);
    check("t3_c4_addr", bus_if.imem_req_addr, 32'h100); step();
    settle(); check("t3_c5_dec_valid", bus_if.dec_valid, 0);
    check("t3_c5_addr", bus_if.imem_req_addr, 32'h104); step();
    settle(); check("t3_c6_dec_valid", bus_if.dec_valid, 0);
    check("t3_c6_addr", bus_if.imem_req_addr, 32'h108); step();
    settle(); check("t3_c7_dec_valid", bus_if.dec_valid, 0); step();
    settle(); check("t3_c8_dec_valid", bus_if.dec_valid, 1);
    check("t3_c8_dec_pc", bus_if.dec_pc, 32'h100);
    check("t3_c8_dec_op", bus_if.dec_op, 32'hC0DE_0100); step();

    // 4: misaligned redirect target
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0103;
    settle(); step();
    bus_if.redirect_valid = 1'b0;
    settle(); check("t4_req_valid", bus_if.imem_req_valid, 1);
    check("t4_addr", bus_if.imem_req_addr, 32'h100); step();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      settle();
      if (bus_if.dec_valid) begin
        found = 1;
        check("t4_dec_pc", bus_if.dec_pc, 32'h100);
        check("t4_dec_op", bus_if.dec_op, 32'hC0DE_0100);
      end
      step();
    end
    check("t4_dec_valid_seen", 64'(found), 1);

    // 5: redirect coincident with a response and a pending pop, two in flight
    do_reset(2);
    bus_if.dec_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      settle(); step();
    end
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h200;
    settle(); check("t5_redir_dec_valid", bus_if.dec_valid, 0);
    check("t5_redir_req_valid", bus_if.imem_req_valid, 0); step();
    bus_if.redirect_valid = 1'b0;
    settle(); check("t5_c5_req_valid", bus_if.imem_req_valid, 1);
    check("t5_c5_addr", bus_if.imem_req_addr, 32'h200);
    check("t5_c5_dec_valid", bus_if.dec_valid, 0); step();
    settle(); check("t5_c6_dec_valid", bus_if.dec_valid, 0);
    check("t5_c6_addr", bus_if.imem_req_addr, 32'h204); step();
    settle(); check("t5_c7_dec_valid", bus_if.dec_valid, 0); step();
    settle(); check("t5_c8_dec_valid", bus_if.dec_valid, 1);
    check("t5_c8_dec_pc", bus_if.dec_pc, 32'h200);
    check("t5_c8_dec_op", bus_if.dec_op, 32'hC0DE_0200); step();

    // 6: asynchronous reset mid-cycle while streaming
    do_reset(1);
    bus_if.dec_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      settle(); step();
    end
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_req_valid", bus_if.imem_req_valid, 0);
    check("t6_async_dec_valid", bus_if.dec_valid, 0);
    check("t6_async_dec_op", bus_if.dec_op, 0);
    check("t6_async_dec_pc", bus_if.dec_pc, 0);
    do_reset(1);
    settle(); check("t6_restart_req_valid", bus_if.imem_req_valid, 1);
    check("t6_restart_addr", bus_if.imem_req_addr, 32'h0); step();
    settle(); check("t6_no_stale_dec_valid", bus_if.dec_valid, 0); step();
    settle(); check("t6_first_dec_valid", bus_if.dec_valid, 1);
    check("t6_first_dec_pc", bus_if.dec_pc, 32'h0);
    check("t6_first_dec_op", bus_if.dec_op, 32'hC0DE_0000); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
